fp_addsub_arb: RTL and testbench
================================

FP_ADDSUB_ARB -- requirements
Module: fp_addsub_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter precision_LEN, default 64, giving the IEEE-754 operand width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port srstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-requester operation request.
REQ-006 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept, one-hot or zero.
REQ-007 SHALL have port req_a, input, NUM_REQ*precision_LEN bits: packed operand A; slice i belongs to requester i.
REQ-008 SHALL have port req_b, input, NUM_REQ*precision_LEN bits: packed operand B.
REQ-009 SHALL have port req_sub, input, NUM_REQ bits: 1 = subtract, 0 = add.
REQ-010 SHALL have port rsp_valid, output, NUM_REQ bits: result available for requester i, one-hot or zero.
REQ-011 SHALL have port rsp_ready, input, NUM_REQ bits: requester i consumes its result.
REQ-012 SHALL have port rsp_data, output, precision_LEN bits: result, shared by all requesters.
REQ-013 SHALL have ports au_a and au_b, output, precision_LEN bits each, and au_add_n, output, 1 bit: operands and add/sub control to the shared add/sub unit.
REQ-014 SHALL have port au_enable, output, 1 bit: start pulse to the add/sub unit.
REQ-015 SHALL have ports au_result, input, precision_LEN bits, and au_valid, input, 1 bit: result and its valid pulse from the add/sub unit.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-018 In IDLE, SHALL grant by round-robin the lowest-index requester with req_valid high, starting at pointer rr_ptr and wrapping from NUM_REQ-1 to 0.
REQ-019 SHALL drive req_ready combinationally high for the granted requester only, in IDLE only; the accept edge registers req_a, req_b, req_sub and the grant index and moves the FSM to ISSUE.
REQ-020 SHALL set rr_ptr to grant index + 1, modulo NUM_REQ, on each accept.
REQ-021 SHALL drive au_a, au_b and au_add_n from registers that are held constant from ISSUE until au_valid is seen.
REQ-022 SHALL assert au_enable for exactly one cycle, the ISSUE cycle, and move to WAIT.
REQ-023 In WAIT, SHALL capture au_result into rsp_data when au_valid is high and move to RESP; with a request accepted at edge T, au_valid arrives in cycle T+3.
REQ-024 SHALL assert a WAIT watchdog: if au_valid is absent for 8 cycles, load rsp_data with the quiet NaN (0x7FF8000000000000 for 64-bit) and move to RESP.
REQ-025 In RESP, SHALL hold rsp_valid high for the grant owner, with rsp_data stable, until rsp_ready for that bit is high; then return to IDLE.
REQ-026 SHALL ignore au_valid outside WAIT, and SHALL ignore rsp_ready bits of non-owners.
REQ-027 SHALL allow the minimum accept-to-accept spacing to be 5 cycles when rsp_ready is held high.
REQ-028 SHALL treat req_valid dropped in the same cycle as the grant as no request: no accept occurs, and the grant is re-evaluated.

Reset
REQ-029 On srstn low at a clock edge, SHALL set the FSM to IDLE, rr_ptr to 0, and au_enable, rsp_valid, busy and req_ready to 0, and SHALL clear the operand and rsp_data registers to 0.
REQ-030 Reset mid-operation SHALL discard the in-flight operation without a response; the add/sub unit shares srstn.

Structure
REQ-031 SHALL place the FSM state encoding, the watchdog limit (8) and the quiet NaN constant in a shared package, fp_pkg.
REQ-032 SHALL contain one sub-module, rr_arbiter (NUM_REQ requests plus pointer in, one-hot grant plus index out, combinational); the add/sub unit is instantiated outside this block.

Verification
REQ-033 Single request: requester 0 submits 0x3FF0000000000000 + 0x4000000000000000, add -> au_enable pulses one cycle after the accept, rsp_valid[0] is high at T+4 with rsp_data 0x4008000000000000.
REQ-034 Round-robin: all four req_valid held high -> grants are in the order 0,1,2,3,0, each spaced 5 cycles apart with rsp_ready tied high.
REQ-035 Backpressure: rsp_ready[2] is held low 10 cycles -> rsp_valid[2] and rsp_data stay stable, req_ready stays 0 and busy stays 1 throughout.
REQ-036 Subtract: requester 1 submits 0x4008000000000000 - 0x3FF0000000000000 -> rsp_data is 0x4000000000000000.
REQ-037 Watchdog: the model suppresses au_valid -> rsp_data is 0x7FF8000000000000 after 8 WAIT cycles.
REQ-038 Reset in WAIT: srstn is pulled low for one cycle -> there is no rsp_valid, busy is 0, and the next grant goes to requester 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants for the FP add/sub arbiter: FSM encoding, watchdog limit, quiet NaN.
package fp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int WD_LIMIT = 8;
    localparam int WD_W     = 4;

    localparam logic [63:0] QNAN_64 = 64'h7FF8_0000_0000_0000;
    localparam logic [31:0] QNAN_32 = 32'h7FC0_0000;

    // Canonical quiet NaN for binary32/binary64, right-aligned in 64 bits.
    function automatic logic [63:0] qnan_bits(input int width);
        return (width == 32) ? {32'h0, QNAN_32} : QNAN_64;
    endfunction

endpackage

// File: rtl/fp_addsub_arb_rr_arbiter.sv
// Combinational round-robin arbiter: lowest index at or after ptr wins, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int   j;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_addsub_arb.sv
// Shares one external FP add/sub unit among NUM_REQ requesters, one operation at a time.
module fp_addsub_arb
    import fp_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int precision_LEN = 64
) (
    input  logic                               clk,
    input  logic                               srstn,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*precision_LEN-1:0]   req_a,
    input  logic [NUM_REQ*precision_LEN-1:0]   req_b,
    input  logic [NUM_REQ-1:0]                 req_sub,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [precision_LEN-1:0]           rsp_data,
    output logic [precision_LEN-1:0]           au_a,
    output logic [precision_LEN-1:0]           au_b,
    output logic                               au_add_n,
    output logic                               au_enable,
    input  logic [precision_LEN-1:0]           au_result,
    input  logic                               au_valid,
    output logic                               busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    // Only binary32/binary64 operands have a defined NaN pattern here.
    localparam logic [63:0] QNAN_FULL = qnan_bits(precision_LEN);
    localparam logic [precision_LEN-1:0] QNAN = QNAN_FULL[precision_LEN-1:0];

    logic [1:0]               state_q, state_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [precision_LEN-1:0] a_q, a_d, b_q, b_d;
    logic                     sub_q, sub_d;
    logic [precision_LEN-1:0] rsp_data_q, rsp_data_d;
    logic [WD_W-1:0]          wd_cnt_q, wd_cnt_d;

    logic [NUM_REQ-1:0]       grant;
    logic [IDX_W-1:0]         grant_idx;
    logic                     accept;
    logic [precision_LEN-1:0] a_sel, b_sel;
    logic [NUM_REQ-1:0]       owner_oh;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant tracks req_valid combinationally, so a dropped request simply is not granted.
    assign accept    = srstn && (state_q == ST_IDLE) && (|grant);
    assign req_ready = accept ? grant : '0;

    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*precision_LEN +: precision_LEN];
                b_sel = req_b[i*precision_LEN +: precision_LEN];
            end
        end
        owner_oh[owner_q] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        sub_d      = sub_q;
        rsp_data_d = rsp_data_q;
        wd_cnt_d   = wd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d      = a_sel;
                    b_d      = b_sel;
                    sub_d    = req_sub[grant_idx];
                    owner_d  = grant_idx;
                    rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (au_valid) begin
                    rsp_data_d = au_result;
                    state_d    = ST_RESP;
                end else if (wd_cnt_q == WD_W'(WD_LIMIT - 1)) begin
                    rsp_data_d = QNAN;
                    state_d    = ST_RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            rsp_data_q <= '0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sub_q      <= sub_d;
            rsp_data_q <= rsp_data_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP) ? owner_oh : '0;
    assign rsp_data  = rsp_data_q;
    assign au_a      = a_q;
    assign au_b      = b_q;
    assign au_add_n  = sub_q;
    assign au_enable = (state_q == ST_ISSUE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_addsub_arb.sv
// Directed bench for fp_addsub_arb with a behavioural add/sub unit and a response scoreboard.
module tb_fp_addsub_arb;

    localparam int N = 4;
    localparam int P = 64;

    localparam logic [63:0] ONE     = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] TWO     = 64'h4000_0000_0000_0000;
    localparam logic [63:0] THREE   = 64'h4008_0000_0000_0000;
    localparam logic [63:0] FIVE    = 64'h4014_0000_0000_0000;
    localparam logic [63:0] QUARTER = 64'h3FD0_0000_0000_0000;
    localparam logic [63:0] F5P25   = 64'h4015_0000_0000_0000;
    localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;

    typedef struct {
        int          idx;
        logic [63:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           srstn;
    logic [N-1:0]   req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
    logic [N*P-1:0] req_a, req_b;
    logic [P-1:0]   rsp_data, au_a, au_b, au_result;
    logic           au_add_n, au_enable, au_valid, busy;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];
    int   acc_t[$];
    int   acc_i[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_addsub_arb #(.NUM_REQ(N), .precision_LEN(P)) dut (
        .clk       (clk),
        .srstn     (srstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .au_a      (au_a),
        .au_b      (au_b),
        .au_add_n  (au_add_n),
        .au_enable (au_enable),
        .au_result (au_result),
        .au_valid  (au_valid),
        .busy      (busy)
    );

    function automatic logic [63:0] fop(input logic [63:0] a, input logic [63:0] b, input logic sub);
        real r;
        r = sub ? ($bitstoreal(a) - $bitstoreal(b)) : ($bitstoreal(a) + $bitstoreal(b));
        return $realtobits(r);
    endfunction

    // Add/sub unit model: result valid two edges after it samples au_enable.
    logic        s1, s2, suppress;
    logic [63:0] res_q;
    always @(posedge clk) begin
        if (!srstn) begin
            s1 <= 1'b0; s2 <= 1'b0; res_q <= '0;
        end else begin
            s1 <= au_enable;
            s2 <= s1 && !suppress;
            if (s1) res_q <= fop(au_a, au_b, au_add_n);
        end
    end
    assign au_valid  = s2;
    assign au_result = res_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: logs accepts and checks every completed response against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (srstn === 1'b1) begin
            if ((req_ready & req_valid) != '0) begin
                acc_t.push_back(cyc);
                for (int i = 0; i < N; i++) if (req_ready[i]) acc_i.push_back(i);
            end
            if ((rsp_valid & rsp_ready) != '0) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_owner", 64'(rsp_valid), 64'(1) << e.idx);
                    chk("sb_data", rsp_data, e.data);
                end
            end
        end
    end

    // Called at a negedge; returns #1 after the accepting posedge (edge T).
    task automatic submit(input int idx, input logic [63:0] a, input logic [63:0] b, input logic sub);
        bit done;
        done = 1'b0;
        req_a[idx*P +: P] = a;
        req_b[idx*P +: P] = b;
        req_sub[idx]      = sub;
        req_valid[idx]    = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (req_ready[idx]) begin
                @(posedge clk);
                #1;
                req_valid[idx] = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            chk("accept_timeout", 64'(req_ready), 64'(1) << idx);
            req_valid[idx] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1'b1;
        end
        chk("idle_timeout", 64'(done), 64'd1);
    endtask

    logic [63:0] rr_a[N];
    logic [63:0] rr_b[N];

    // Cycle numbering below: the k-th negedge after edge T lies in the cycle ending at edge T+k.
    initial begin
        srstn     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = '1;
        suppress  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_au_enable", 64'(au_enable), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_au_a", au_a, 64'd0);
        chk("rst_au_b", au_b, 64'd0);
        req_valid = '0;
        srstn     = 1'b1;
        @(negedge clk);

        // Single add from requester 0
        sb.push_back('{0, THREE});
        submit(0, ONE, TWO, 1'b0);
        @(negedge clk);
        chk("single_au_enable_t1", 64'(au_enable), 64'd1);
        chk("single_busy", 64'(busy), 64'd1);
        chk("single_au_a", au_a, ONE);
        chk("single_au_b", au_b, TWO);
        chk("single_au_add_n", 64'(au_add_n), 64'd0);
        @(negedge clk);
        chk("single_au_enable_t2", 64'(au_enable), 64'd0);
        @(negedge clk);
        chk("single_rsp_valid_t3", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("single_rsp_valid_t4", 64'(rsp_valid), 64'd1);
        chk("single_rsp_data_t4", rsp_data, THREE);
        wait_idle();

        // Subtract from requester 1
        sb.push_back('{1, TWO});
        submit(1, THREE, ONE, 1'b1);
        @(negedge clk);
        chk("sub_au_add_n", 64'(au_add_n), 64'd1);
        chk("sub_au_enable", 64'(au_enable), 64'd1);
        wait_idle();

        // Backpressure on requester 2; other requesters pending and ready-high must be ignored
        rsp_ready = '0;
        sb.push_back('{2, F5P25});
        submit(2, FIVE, QUARTER, 1'b0);
        req_valid = 4'b1011;
        rsp_ready = 4'b1011;
        repeat (4) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'b0100);
            chk("bp_rsp_data", rsp_data, F5P25);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = '1;
        wait_idle();

        // Watchdog on requester 3
        suppress = 1'b1;
        sb.push_back('{3, QNAN});
        submit(3, ONE, ONE, 1'b0);
        repeat (9) @(negedge clk);
        chk("wd_rsp_valid_t9", 64'(rsp_valid), 64'd0);
        chk("wd_busy_t9", 64'(busy), 64'd1);
        @(negedge clk);
        chk("wd_rsp_valid_t10", 64'(rsp_valid), 64'b1000);
        chk("wd_rsp_data_t10", rsp_data, QNAN);
        wait_idle();
        suppress = 1'b0;

        // Round-robin with all requesters pending
        acc_t.delete();
        acc_i.delete();
        req_sub = 4'b1010;
        for (int i = 0; i < N; i++) begin
            rr_a[i] = $realtobits(1.5 + i);
            rr_b[i] = $realtobits(0.25 * (i + 1));
            req_a[i*P +: P] = rr_a[i];
            req_b[i*P +: P] = rr_b[i];
        end
        for (int k = 0; k < 5; k++)
            sb.push_back('{k % N, fop(rr_a[k % N], rr_b[k % N], req_sub[k % N])});
        req_valid = '1;
        for (int c = 0; c < 80 && acc_t.size() < 5; c++) begin
            @(negedge clk);
            #3;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("rr_accept_count", 64'(acc_t.size()), 64'd5);
        if (acc_t.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", 64'(acc_i[k]), 64'(k % N));
            for (int k = 1; k < 5; k++) chk("rr_spacing", 64'(acc_t[k] - acc_t[k-1]), 64'd5);
        end
        wait_idle();

        // Reset while waiting on the add/sub unit
        req_sub = '0;
        submit(2, FIVE, ONE, 1'b0);
        @(negedge clk);
        @(negedge clk);
        srstn = 1'b0;
        @(negedge clk);
        srstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rstw_busy", 64'(busy), 64'd0);
        end
        sb.push_back('{0, fop(rr_a[0], rr_b[0], 1'b0)});
        req_valid = '1;
        #1;
        chk("rstw_next_grant", 64'(req_ready), 64'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
